// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: owns HI/LO, models multi-cycle MD latency with a busy counter
// and requests pipeline stalls while an MD op in D would observe an unfinished result.
module md_scheduler #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q, b_q;

    logic [63:0] prod_s, prod_u;
    logic        neg_a, neg_b, div_zero;
    logic [31:0] abs_a, abs_b, uq, ur, dq, dr;

    // Results are formed from the latched operands and consumed on the final busy edge.
    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'b0, a_q} * {32'b0, b_q};
        neg_a    = (op_q == OP_DIV) && a_q[31];
        neg_b    = (op_q == OP_DIV) && b_q[31];
        abs_a    = neg_a ? -a_q : a_q;
        abs_b    = neg_b ? -b_q : b_q;
        div_zero = (b_q == 32'd0);
        uq       = div_zero ? '0 : abs_a / abs_b;
        ur       = div_zero ? '0 : abs_a % abs_b;
        dq       = (neg_a ^ neg_b) ? -uq : uq;
        dr       = neg_a ? -ur : ur;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op <= OP_DIVU) begin
                            op_q  <= op;
                            a_q   <= rs_val;
                            b_q   <= rt_val;
                            cnt   <= (op <= OP_MULTU) ? MUL_N : DIV_N;
                            state <= RUN;
                            busy  <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        case (op_q)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            default: begin
                                if (!div_zero) begin
                                    hi <= dr;
                                    lo <= dq;
                                end
                            end
                        endcase
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign stall_md = md_use_D & ((start & (op <= OP_DIVU)) | busy);

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: table of MD ops with hand-computed HI/LO plus
// hand-written sequences for reset, stalls, start-during-run and reset mid-divide.
module tb_md_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        md_use_D;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check busy/stall through the busy window, then the result.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el);
        tick();
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        chk({nm, " stall_issue"}, {31'b0, stall_md}, {31'b0, md_use_D & (o <= 3'd3)});
        tick();
        start = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy_c%0d", nm, k), {31'b0, busy}, 32'd1);
            chk($sformatf("%s stall_c%0d", nm, k), {31'b0, stall_md}, {31'b0, md_use_D});
            tick();
        end
        @(negedge clk);
        chk({nm, " busy_done"}, {31'b0, busy}, 32'd0);
        chk({nm, " stall_done"}, {31'b0, stall_md}, 32'd0);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,         5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,         5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,         10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,         10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'd2, 32'd5,        32'd0,         10, 32'h00000001, 32'h00000003};
        vecs[5]  = '{3'd3, 32'hFFFFFFFF, 32'd0,         10, 32'h00000001, 32'h00000003};
        vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,  10, 32'h00000000, 32'h80000000};
        vecs[7]  = '{3'd4, 32'h12345678, 32'd0,         0,  32'h12345678, 32'h80000000};
        vecs[8]  = '{3'd5, 32'h9ABCDEF0, 32'd0,         0,  32'h12345678, 32'h9ABCDEF0};
        vecs[9]  = '{3'd6, 32'hDEADBEEF, 32'hDEADBEEF,  0,  32'h12345678, 32'h9ABCDEF0};
        vecs[10] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,  5,  32'h3FFFFFFF, 32'h00000001};
        vecs[11] = '{3'd0, 32'h80000000, 32'h80000000,  5,  32'h40000000, 32'h00000000};
        vecs[12] = '{3'd2, 32'd7,        32'hFFFFFFFE,  10, 32'h00000001, 32'hFFFFFFFD};
        vecs[13] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,  10, 32'h80000000, 32'h00000000};

        // Reset held with a MULT presented: nothing may start.
        reset = 1'b0; start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd3; md_use_D = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst stall", {31'b0, stall_md}, 32'd0);
        tick();
        @(negedge clk);
        chk("rst hold busy", {31'b0, busy}, 32'd0);
        reset = 1'b1; start = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].n, vecs[i].hi, vecs[i].lo);

        // Stall from issue through T+5 while D holds an MD op.
        md_use_D = 1'b1;
        run_op("stall_mult", 3'd0, 32'd2, 32'd3, 5, 32'd0, 32'd6);
        md_use_D = 1'b0;
        run_op("nostall_mult", 3'd1, 32'd4, 32'd5, 5, 32'd0, 32'd20);

        // start during RUN is ignored.
        tick();
        start = 1'b1; op = 3'd0; rs_val = 32'd6; rt_val = 32'd7;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("ign busy_c%0d", k), {31'b0, busy}, 32'd1);
            tick();
            if (k == 1) begin start = 1'b1; op = 3'd4; rs_val = 32'hDEADDEAD; end
            if (k == 2) start = 1'b0;
        end
        @(negedge clk);
        chk("ign busy_done", {31'b0, busy}, 32'd0);
        chk("ign hi", hi, 32'd0);
        chk("ign lo", lo, 32'd42);

        // Reset at T+3 of a DIV aborts it and clears HI/LO.
        run_op("pre_div", 3'd4, 32'hAAAA5555, 32'd0, 0, 32'hAAAA5555, 32'd42);
        tick();
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        run_op("post_abort", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
